mdc_feed: RTL and testbench
===========================

MDC_FEED -- requirements
Module: mdc_feed

Interface
REQ-001 Parameter DEPTH, default 2: operand FIFO depth in pairs, power of two, minimum 2.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024: maximum RUN cycles before abort; used only with MDC_FEED_TIMEOUT_EN.
REQ-003 Port clk  input  1: single clock; all state changes on the rising edge.
REQ-004 Port rst_n  input  1: reset, asynchronous assert, active-low.
REQ-005 Ports in_valid input 1, in_ready output 1, in_a input 32, in_b input 32: operand-pair upstream handshake.
REQ-006 Ports core_ld output 1, core_a output 32, core_b output 32: load strobe and operands to the subtractive GCD core.
REQ-007 Ports core_res input 32, core_done input 1: GCD core result and done flag.
REQ-008 Ports out_valid output 1, out_ready input 1, out_res output 32, out_err output 1: result downstream handshake.
REQ-009 Port busy  output 1: high whenever the FSM is not IDLE or the FIFO is non-empty.

Function
REQ-010 Pair accepted on a rising edge with in_valid && in_ready; in_ready = FIFO not full; no push when full, even if the same cycle pops.
REQ-011 FIFO order is strict first-in first-out; occupancy count ranges 0..DEPTH; pointers wrap modulo DEPTH.
REQ-012 FSM states: IDLE, LOAD, RUN, HOLD.
REQ-013 IDLE -> LOAD when FIFO non-empty; otherwise stay in IDLE.
REQ-014 LOAD lasts exactly one cycle: core_ld=1, core_a/core_b = FIFO head, head popped at the end of the cycle; next state RUN.
REQ-015 core_ld is 0 in every state except LOAD; core_a/core_b drive the FIFO head at all times (0 when empty).
REQ-016 RUN samples core_done each cycle, starting with the first cycle after LOAD; on core_done=1, core_res registers into out_res, out_err=0, next state HOLD.
REQ-017 HOLD: out_valid=1; out_res/out_err stable until the handshake; on out_ready=1, go to LOAD if FIFO non-empty, else IDLE.
REQ-018 out_valid is high only in HOLD and never depends combinationally on out_ready.
REQ-019 Operand of zero (e.g. 0,7): core_done is already high in the first RUN cycle; result = the other operand; (0,0) yields 0.
REQ-020 Minimum latency from push into an empty FIFO to out_valid: 3 cycles (IDLE->LOAD->RUN->HOLD with immediate done).
REQ-021 Push during LOAD/RUN/HOLD is permitted while not full; pop occurs only in LOAD.

Reset
REQ-022 rst_n low: FSM=IDLE, FIFO empty, in_ready=1, core_ld=0, out_valid=0, out_res=0, out_err=0, busy=0, timeout counter=0.
REQ-023 Reset mid-RUN or mid-HOLD discards the in-flight pair and all queued pairs; the core is not reset and is re-initialised by the next LOAD.

Configuration
REQ-024 Macro MDC_FEED_TIMEOUT_EN defined: 32-bit counter cleared in LOAD, incremented each RUN cycle without done; on reaching TIMEOUT_CYCLES, out_res=0, out_err=1, next state HOLD.
REQ-025 On timeout the core keeps iterating; the next LOAD overrides it because ld has priority in the core.
REQ-026 Macro undefined: no counter; RUN waits indefinitely; out_err is tied to 0.

Structure
REQ-027 Package mdc_pkg holds MDC_W=32 and the FSM state typedef (IDLE, LOAD, RUN, HOLD).
REQ-028 One sub-module, mdc_fifo: parameterised DEPTH x 64-bit FIFO with full/empty flags, reset by rst_n.
REQ-029 Top-level mdc_feed contains the FSM, the result register and the optional timeout counter only.

Verification
REQ-030 Bench instantiates mdc_feed with the team's subtractive GCD core and a reference model.
REQ-031 Push (12,18), out_ready=1 -> out_valid with out_res=6, out_err=0, then busy=0.
REQ-032 Push (0,7) into an idle block -> out_res=7 exactly 3 cycles after the push edge.
REQ-033 Push (48,36),(35,14),(17,5) back-to-back with DEPTH=2, out_ready low for 10 cycles -> in_ready drops when full; results 12,7,1 in order, out_res stable while stalled.
REQ-034 Assert rst_n low in the RUN cycle of (1000,3) -> all outputs at reset values; a following push of (9,6) returns 3.
REQ-035 MDC_FEED_TIMEOUT_EN defined, TIMEOUT_CYCLES=64, push (32'hFFFFFFFF,1) -> out_err=1 and out_res=0 after 64 RUN cycles; the next pair (8,12) returns 4.

Source files
------------

// File: rtl/mdc_pkg.sv
// Shared width and FSM state type for the GCD operand feeder.
package mdc_pkg;

  localparam int MDC_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HOLD = 2'd3
  } mdc_state_e;

endpackage

// File: rtl/mdc_feed_if.sv
// Upstream operand, GCD core and downstream result signals of mdc_feed.
// master = the feeder itself, slave = its environment (source, core, sink).
interface mdc_feed_if;

  logic                       in_valid;
  logic                       in_ready;
  logic [mdc_pkg::MDC_W-1:0]  in_a;
  logic [mdc_pkg::MDC_W-1:0]  in_b;
  logic                       core_ld;
  logic [mdc_pkg::MDC_W-1:0]  core_a;
  logic [mdc_pkg::MDC_W-1:0]  core_b;
  logic [mdc_pkg::MDC_W-1:0]  core_res;
  logic                       core_done;
  logic                       out_valid;
  logic                       out_ready;
  logic [mdc_pkg::MDC_W-1:0]  out_res;
  logic                       out_err;
  logic                       busy;

  modport master (
    input  in_valid, in_a, in_b, core_res, core_done, out_ready,
    output in_ready, core_ld, core_a, core_b, out_valid, out_res, out_err, busy
  );

  modport slave (
    output in_valid, in_a, in_b, core_res, core_done, out_ready,
    input  in_ready, core_ld, core_a, core_b, out_valid, out_res, out_err, busy
  );

endinterface

// File: rtl/mdc_fifo.sv
// Operand-pair FIFO, DEPTH entries of 64 bits; head reads 0 while empty.
// DEPTH must be a power of two so the pointers wrap naturally.
module mdc_fifo #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_i,
  input  logic [63:0] din_i,
  input  logic        pop_i,
  output logic [63:0] dout_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [63:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign dout_o  = empty_o ? 64'd0 : mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_ok) wr_d = wr_q + PTR_W'(1);
    if (pop_ok)  rd_d = rd_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/mdc_feed.sv
// Feeds queued operand pairs to a subtractive GCD core and holds each result
// until taken. Optional RUN watchdog enabled by `define MDC_FEED_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no work, waiting for a queued pair
// LOAD  | one cycle: strobe core_ld with the FIFO head, pop it
// RUN   | core iterating, wait for core_done (or watchdog expiry)
// HOLD  | out_valid high until the downstream accepts the result
module mdc_feed
  import mdc_pkg::*;
#(
  parameter int DEPTH          = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  mdc_feed_if.master  bus
);

  mdc_state_e       state_q, state_d;
  logic [MDC_W-1:0] res_q, res_d;
  logic [63:0]      head;
  logic             full, empty, pop, tmo_hit;

  mdc_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (bus.in_valid),
    .din_i   ({bus.in_a, bus.in_b}),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign pop          = (state_q == LOAD);
  assign bus.in_ready = !full;
  assign bus.core_ld  = (state_q == LOAD);
  assign bus.core_a   = head[63:32];
  assign bus.core_b   = head[31:0];
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_res  = res_q;
  assign bus.busy     = (state_q != IDLE) || !empty;

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    case (state_q)
      IDLE: if (!empty) state_d = LOAD;
      LOAD: state_d = RUN;
      RUN: begin
        if (bus.core_done) begin
          res_d   = bus.core_res;
          state_d = HOLD;
        end else if (tmo_hit) begin
          res_d   = '0;
          state_d = HOLD;
        end
      end
      HOLD: if (bus.out_ready) state_d = empty ? IDLE : LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
    end
  end

`ifdef MDC_FEED_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  // Counts RUN cycles without done; the core is left running on expiry and
  // gets overridden by the next load.
  always_comb begin
    cnt_d   = cnt_q;
    err_d   = err_q;
    tmo_hit = 1'b0;
    if (state_q == LOAD) begin
      cnt_d = '0;
    end else if (state_q == RUN) begin
      if (bus.core_done) begin
        err_d = 1'b0;
      end else begin
        cnt_d   = cnt_q + 32'd1;
        tmo_hit = ((cnt_q + 32'd1) == 32'(TIMEOUT_CYCLES));
        if (tmo_hit) err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus.out_err = err_q;
`else
  logic unused_tmo;

  assign tmo_hit     = 1'b0;
  assign bus.out_err = 1'b0;
  assign unused_tmo  = ^TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_mdc_feed.sv
// Bench for mdc_feed with a behavioural subtractive GCD core and a Euclid
// reference model feeding a result scoreboard.
module tb_mdc_feed;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mdc_feed_if bus ();

  mdc_feed #(.DEPTH(2), .TIMEOUT_CYCLES(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  // subtractive GCD core: ld has priority, no reset
  logic [31:0] ca = 32'd0;
  logic [31:0] cb = 32'd0;
  logic        cdone;
  assign cdone        = (ca == cb) || (ca == 32'd0) || (cb == 32'd0);
  assign bus.core_done = cdone;
  assign bus.core_res = (ca == 32'd0) ? cb : ca;
  always @(posedge clk) begin
    if (bus.core_ld) begin
      ca <= bus.core_a;
      cb <= bus.core_b;
    end else if (!cdone) begin
      if (ca > cb) ca <= ca - cb;
      else         cb <= cb - ca;
    end
  end

  int n_cmp = 0;
  int n_mis = 0;
  logic [32:0] exp_q[$];

  function automatic logic [31:0] gcd_ref(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, t;
    x = a;
    y = b;
    while (y != 32'd0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic fail_bound(input string name);
    n_cmp++;
    n_mis++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // scoreboard monitor: compares each accepted result against the queue head
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        fail_bound("unexpected_result");
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("result_res", 64'(bus.out_res), 64'(e[31:0]));
        check("result_err", 64'(bus.out_err), 64'(e[32]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [32:0] exp);
    int k;
    k = 0;
    while (!bus.in_ready && k < 300) begin
      step();
      k++;
    end
    if (!bus.in_ready) begin
      fail_bound("push_wait");
      return;
    end
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    exp_q.push_back(exp);
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic push_gcd(input logic [31:0] a, input logic [31:0] b);
    push(a, b, {1'b0, gcd_ref(a, b)});
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || bus.busy) && k < 2000) begin
      step();
      k++;
    end
    if (exp_q.size() != 0 || bus.busy) fail_bound(name);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  64'(bus.in_ready),  64'd1);
    check({tag, "_core_ld"},   64'(bus.core_ld),   64'd0);
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_out_res"},   64'(bus.out_res),   64'd0);
    check({tag, "_out_err"},   64'(bus.out_err),   64'd0);
    check({tag, "_busy"},      64'(bus.busy),      64'd0);
    check({tag, "_core_a"},    64'({bus.core_a, bus.core_b}), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int k;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    repeat (2) step();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    step();

    // basic pair, then the block returns to idle
    push_gcd(32'd12, 32'd18);
    drain("drain_12_18");
    repeat (2) step();
    check("idle_busy", 64'(bus.busy), 64'd0);

    // zero operand: result three cycles after the push edge
    push_gcd(32'd0, 32'd7);
    step();
    step();
    check("lat_early_valid", 64'(bus.out_valid), 64'd0);
    step();
    check("lat_valid", 64'(bus.out_valid), 64'd1);
    check("lat_res", 64'(bus.out_res), 64'd7);
    drain("drain_0_7");

    push_gcd(32'd0, 32'd0);
    push_gcd(32'd7, 32'd0);
    push_gcd(32'd21, 32'd14);
    drain("drain_misc");

    // back-to-back with downstream stalled
    bus.out_ready = 1'b0;
    push_gcd(32'd48, 32'd36);
    push_gcd(32'd35, 32'd14);
    push_gcd(32'd17, 32'd5);
    k = 0;
    while (!bus.out_valid && k < 300) begin
      step();
      k++;
    end
    if (!bus.out_valid) fail_bound("stall_wait_valid");
    for (int i = 0; i < 10; i++) begin
      check("stall_valid", 64'(bus.out_valid), 64'd1);
      check("stall_res", 64'(bus.out_res), 64'd12);
      check("stall_in_ready", 64'(bus.in_ready), 64'd0);
      step();
    end
    bus.out_ready = 1'b1;
    drain("drain_stall");

    // reset during RUN discards the in-flight pair
    push_gcd(32'd1000, 32'd3);
    k = 0;
    while (!bus.core_ld && k < 20) begin
      step();
      k++;
    end
    if (!bus.core_ld) fail_bound("rst_wait_load");
    step();
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_reset_outputs("midrun_reset");
    step();
    rst_n = 1'b1;
    step();
    push_gcd(32'd9, 32'd6);
    drain("drain_9_6");

`ifdef MDC_FEED_TIMEOUT_EN
    push(32'hFFFF_FFFF, 32'd1, {1'b1, 32'd0});
    k = 0;
    while (!bus.core_ld && k < 20) begin
      step();
      k++;
    end
    if (!bus.core_ld) fail_bound("tmo_wait_load");
    k = 0;
    while (!bus.out_valid && k < 300) begin
      step();
      k++;
    end
    check("tmo_latency", 64'(k), 64'd65);
    drain("drain_tmo");
`endif

    push_gcd(32'd8, 32'd12);
    drain("drain_8_12");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
